// File: rtl/ex_muldiv_pkg.sv
// Shared widths, funct codes and helpers for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned FUNCT_W = 6;
   localparam int unsigned DDATA_W = 64;

   typedef logic [FUNCT_W-1:0] funct_t;
   typedef logic [DATA_W-1:0]  data_t;
   typedef logic [DDATA_W-1:0] ddata_t;

   localparam funct_t FUNCT_MFHI  = 6'h10;
   localparam funct_t FUNCT_MTHI  = 6'h11;
   localparam funct_t FUNCT_MFLO  = 6'h12;
   localparam funct_t FUNCT_MTLO  = 6'h13;
   localparam funct_t FUNCT_MULT  = 6'h18;
   localparam funct_t FUNCT_MULTU = 6'h19;
   localparam funct_t FUNCT_DIV   = 6'h1A;
   localparam funct_t FUNCT_DIVU  = 6'h1B;

   // Context captured when a divide issues, consumed by the fix-up in DONE.
   typedef struct packed {
      logic  dz;
      logic  q_neg;
      logic  r_neg;
      data_t op1;
   } div_ctx_t;

   function automatic data_t magnitude(input data_t v, input logic is_signed);
      return (is_signed && v[DATA_W-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// Unsigned restoring divider core: one quotient bit per cycle for DIV_CYCLES cycles.
module div_iter
   import ex_muldiv_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  start_i,
   input  logic  abort_i,
   input  data_t dividend_i,
   input  data_t divisor_i,
   output logic  busy_o,
   output logic  last_c,
   output data_t quotient_o,
   output data_t remainder_o
);

   localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   data_t            rem_q, rem_d;
   data_t            quo_q, quo_d;
   data_t            dvs_q, dvs_d;
   logic [DATA_W:0]  shifted, diff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
      end
   end

   // The 33-bit trial subtraction borrows into the top bit when the divisor does not fit.
   always_comb begin
      shifted = {rem_q, quo_q[DATA_W-1]};
      diff    = shifted - {1'b0, dvs_q};
      last_c  = busy_q && (cnt_q == CNT_W'(DIV_CYCLES - 1));
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      if (abort_i) begin
         busy_d = 1'b0;
         cnt_d  = '0;
      end else if (start_i) begin
         rem_d  = '0;
         quo_d  = dividend_i;
         dvs_d  = divisor_i;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         if (!diff[DATA_W]) begin
            rem_d = diff[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
         end else begin
            rem_d = shifted[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
         end
         cnt_d = cnt_q + CNT_W'(1);
         if (last_c) begin
            busy_d = 1'b0;
            cnt_d  = '0;
         end
      end
   end

   assign busy_o      = busy_q;
   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit owning HI/LO: single-cycle multiply, iterative divide with stall.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   start,
   input  funct_t funct,
   input  data_t  operand_1,
   input  data_t  operand_2,
   input  logic   flush,
   output logic   stall_req,
   output data_t  result,
   output data_t  hi,
   output data_t  lo
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0] state_q, state_d;
   data_t      hi_q, hi_d, lo_q, lo_d;
   div_ctx_t   ctx_q, ctx_d;
   logic       is_div, is_signed, div_zero, div_start;
   logic       div_busy, div_last;
   data_t      div_quo, div_rem;
   ddata_t     prod_s, prod_u;

   assign is_div    = start && (funct == FUNCT_DIV || funct == FUNCT_DIVU);
   assign is_signed = (funct == FUNCT_DIV);
   assign div_zero  = (operand_2 == '0);

   // Low 64 bits of the product of sign-extended operands equal the signed product.
   assign prod_s = {{DATA_W{operand_1[DATA_W-1]}}, operand_1} *
                   {{DATA_W{operand_2[DATA_W-1]}}, operand_2};
   assign prod_u = {{DATA_W{1'b0}}, operand_1} * {{DATA_W{1'b0}}, operand_2};

   div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div_iter (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (div_start),
      .abort_i    (flush),
      .dividend_i (magnitude(operand_1, is_signed)),
      .divisor_i  (magnitude(operand_2, is_signed)),
      .busy_o     (div_busy),
      .last_c     (div_last),
      .quotient_o (div_quo),
      .remainder_o(div_rem)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (is_div) state_d = div_zero ? S_DONE : S_RUN;
            S_RUN:   if (div_last || !div_busy) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // HI/LO writes, divide issue and stall; flush suppresses all of them.
   always_comb begin
      hi_d      = hi_q;
      lo_d      = lo_q;
      ctx_d     = ctx_q;
      div_start = 1'b0;
      stall_req = rst_n && !flush &&
                  ((state_q == S_IDLE && is_div) || state_q == S_RUN);
      if (!flush) begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  case (funct)
                     FUNCT_MTHI:  hi_d = operand_1;
                     FUNCT_MTLO:  lo_d = operand_1;
                     FUNCT_MULT:  {hi_d, lo_d} = prod_s;
                     FUNCT_MULTU: {hi_d, lo_d} = prod_u;
                     FUNCT_DIV, FUNCT_DIVU: begin
                        ctx_d.dz    = div_zero;
                        ctx_d.q_neg = is_signed && (operand_1[DATA_W-1] ^ operand_2[DATA_W-1]);
                        ctx_d.r_neg = is_signed && operand_1[DATA_W-1];
                        ctx_d.op1   = operand_1;
                        div_start   = !div_zero;
                     end
                     default: ;
                  endcase
               end
            end
            S_DONE: begin
               if (ctx_q.dz) begin
                  lo_d = '1;
                  hi_d = ctx_q.op1;
               end else begin
                  lo_d = ctx_q.q_neg ? -div_quo : div_quo;
                  hi_d = ctx_q.r_neg ? -div_rem : div_rem;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q  <= '0;
         lo_q  <= '0;
         ctx_q <= '0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         ctx_q <= ctx_d;
      end
   end

   always_comb begin
      case (funct)
         FUNCT_MFHI: result = hi_q;
         FUNCT_MFLO: result = lo_q;
         default:    result = '0;
      endcase
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv against an arithmetic model of HI/LO behaviour.
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

   logic        clk, rst_n, start, flush, stall_req;
   logic [5:0]  funct;
   logic [31:0] operand_1, operand_2, result, hi, lo;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] hi_m, lo_m;

   ex_muldiv dut (
      .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
      .operand_1(operand_1), .operand_2(operand_2), .flush(flush),
      .stall_req(stall_req), .result(result), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one instruction held in EX until it leaves; reports what was observed.
   task automatic run_instr(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                            output int stalls, output logic [31:0] res,
                            output logic [31:0] hi_pre, output logic [31:0] lo_pre);
      int n = 0;
      start = 1'b1; funct = f; operand_1 = a; operand_2 = b;
      #1;
      res = result;
      while (stall_req === 1'b1 && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      hi_pre = hi; lo_pre = lo;
      @(posedge clk); #1;
      start = 1'b0; funct = 6'h00;
      stalls = n;
   endtask

   // Architectural model: plain 64-bit arithmetic, truncating division.
   task automatic model_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           output int exp_stalls, output logic [31:0] exp_res);
      longint sa, sb, q, r, p;
      longint unsigned ua, ub, pu;
      sa = longint'($signed(a)); sb = longint'($signed(b));
      ua = {32'h0, a};           ub = {32'h0, b};
      exp_stalls = 0;
      exp_res    = (f == FUNCT_MFHI) ? hi_m : (f == FUNCT_MFLO) ? lo_m : 32'h0;
      case (f)
         FUNCT_MTHI:  hi_m = a;
         FUNCT_MTLO:  lo_m = a;
         FUNCT_MULT:  begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
         FUNCT_MULTU: begin pu = ua * ub; hi_m = pu[63:32]; lo_m = pu[31:0]; end
         FUNCT_DIV, FUNCT_DIVU: begin
            if (b == 32'h0) begin
               exp_stalls = 1; lo_m = 32'hFFFF_FFFF; hi_m = a;
            end else begin
               exp_stalls = 33;
               if (f == FUNCT_DIV) begin q = sa / sb; r = sa % sb; end
               else begin q = longint'(ua / ub); r = longint'(ua % ub); end
               lo_m = q[31:0]; hi_m = r[31:0];
            end
         end
         default: ;
      endcase
   endtask

   task automatic test_reset;
      rst_n = 1'b0; flush = 1'b0; start = 1'b1; funct = FUNCT_DIVU;
      operand_1 = 32'd9; operand_2 = 32'd2;
      #2;
      n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_req); end
      n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
      n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
      funct = FUNCT_MFHI; #1;
      n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
      start = 1'b0; funct = 6'h00;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      hi_m = 32'h0; lo_m = 32'h0;
   endtask

   task automatic test_mult;
      int st; logic [31:0] res, hp, lp;
      run_instr(FUNCT_MULT, 32'hFFFF_FFFE, 32'd3, st, res, hp, lp);
      n_checks++; if (st !== 0) begin n_fail++; $display("FAIL mult_stall: got %0d want 0", st); end
      n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
      n_checks++; if (lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_lo: got %h want fffffffa", lo); end
      run_instr(FUNCT_MULTU, 32'hFFFF_FFFE, 32'd3, st, res, hp, lp);
      n_checks++; if (st !== 0) begin n_fail++; $display("FAIL multu_stall: got %0d want 0", st); end
      n_checks++; if (hi !== 32'h0000_0002) begin n_fail++; $display("FAIL multu_hi: got %h want 00000002", hi); end
      n_checks++; if (lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL multu_lo: got %h want fffffffa", lo); end
      hi_m = 32'h2; lo_m = 32'hFFFF_FFFA;
   endtask

   task automatic test_mt_mf;
      int st; logic [31:0] res, hp, lp;
      run_instr(FUNCT_MTHI, 32'h1234, 32'h0, st, res, hp, lp);
      run_instr(FUNCT_MFHI, 32'h0, 32'h0, st, res, hp, lp);
      n_checks++; if (res !== 32'h1234) begin n_fail++; $display("FAIL mfhi: got %h want 00001234", res); end
      run_instr(FUNCT_MTLO, 32'hABCD, 32'h0, st, res, hp, lp);
      run_instr(FUNCT_MFLO, 32'h0, 32'h0, st, res, hp, lp);
      n_checks++; if (res !== 32'hABCD) begin n_fail++; $display("FAIL mflo: got %h want 0000abcd", res); end
      run_instr(6'h20, 32'h5555_5555, 32'h7, st, res, hp, lp);
      n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL other_result: got %h want 0", res); end
      n_checks++; if (st !== 0) begin n_fail++; $display("FAIL other_stall: got %0d want 0", st); end
      n_checks++; if ({hi, lo} !== {32'h1234, 32'hABCD}) begin n_fail++; $display("FAIL other_nowrite: got %h_%h want 00001234_0000abcd", hi, lo); end
      hi_m = 32'h1234; lo_m = 32'hABCD;
   endtask

   task automatic test_div;
      int st; logic [31:0] res, hp, lp;
      run_instr(FUNCT_DIVU, 32'd100, 32'd7, st, res, hp, lp);
      n_checks++; if (st !== 33) begin n_fail++; $display("FAIL divu_stall: got %0d want 33", st); end
      n_checks++; if ({hp, lp} !== {32'h1234, 32'hABCD}) begin n_fail++; $display("FAIL divu_done_hold: got %h_%h want 00001234_0000abcd", hp, lp); end
      n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %h want 2", hi); end
      n_checks++; if (lo !== 32'hE) begin n_fail++; $display("FAIL divu_lo: got %h want e", lo); end
      run_instr(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, st, res, hp, lp);
      n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
      n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
      run_instr(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st, res, hp, lp);
      n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
      n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL div_ovf_hi: got %h want 0", hi); end
      run_instr(FUNCT_DIVU, 32'd5, 32'd0, st, res, hp, lp);
      n_checks++; if (st !== 1) begin n_fail++; $display("FAIL divz_stall: got %0d want 1", st); end
      n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divz_lo: got %h want ffffffff", lo); end
      n_checks++; if (hi !== 32'd5) begin n_fail++; $display("FAIL divz_hi: got %h want 5", hi); end
      hi_m = 32'd5; lo_m = 32'hFFFF_FFFF;
   endtask

   task automatic test_flush;
      int st; logic [31:0] res, hp, lp;
      start = 1'b1; funct = FUNCT_DIV; operand_1 = 32'd1000; operand_2 = 32'd3;
      repeat (11) begin @(posedge clk); #1; end
      flush = 1'b1; #1;
      n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall_req); end
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0; funct = 6'h00;
      n_checks++; if ({hi, lo} !== {hi_m, lo_m}) begin n_fail++; $display("FAIL flush_nowrite: got %h_%h want %h_%h", hi, lo, hi_m, lo_m); end
      run_instr(FUNCT_MULT, 32'h0001_0000, 32'hFFFF_0000, st, res, hp, lp);
      n_checks++; if (st !== 0) begin n_fail++; $display("FAIL flush_mult_stall: got %0d want 0", st); end
      n_checks++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'h0}) begin n_fail++; $display("FAIL flush_mult: got %h_%h want ffffffff_00000000", hi, lo); end
      hi_m = 32'hFFFF_FFFF; lo_m = 32'h0;
   endtask

   task automatic test_reset_mid_div;
      int st; logic [31:0] res, hp, lp;
      start = 1'b1; funct = FUNCT_DIVU; operand_1 = 32'd77; operand_2 = 32'd5;
      repeat (6) begin @(posedge clk); #1; end
      rst_n = 1'b0; #1;
      n_checks++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL rst_mid_hilo: got %h_%h want 0", hi, lo); end
      n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b want 0", stall_req); end
      start = 1'b0; funct = 6'h00;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run_instr(FUNCT_DIVU, 32'd1000, 32'd33, st, res, hp, lp);
      n_checks++; if (st !== 33) begin n_fail++; $display("FAIL rst_div_stall: got %0d want 33", st); end
      n_checks++; if ({hi, lo} !== {32'd10, 32'd30}) begin n_fail++; $display("FAIL rst_div: got %h_%h want 0000000a_0000001e", hi, lo); end
      hi_m = 32'd10; lo_m = 32'd30;
   endtask

   task automatic test_random;
      int st, exp_st; logic [31:0] res, exp_res, hp, lp, a, b; logic [5:0] f;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 8))
            0: f = FUNCT_MFHI;  1: f = FUNCT_MTHI;  2: f = FUNCT_MFLO;
            3: f = FUNCT_MTLO;  4: f = FUNCT_MULT;  5: f = FUNCT_MULTU;
            6: f = FUNCT_DIV;   7: f = FUNCT_DIVU;  default: f = 6'h21;
         endcase
         a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom();
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
         if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
         model_op(f, a, b, exp_st, exp_res);
         run_instr(f, a, b, st, res, hp, lp);
         n_checks++; if (st !== exp_st) begin n_fail++; $display("FAIL rnd%0d_stall f=%h: got %0d want %0d", i, f, st, exp_st); end
         n_checks++; if (res !== exp_res) begin n_fail++; $display("FAIL rnd%0d_result f=%h: got %h want %h", i, f, res, exp_res); end
         n_checks++; if ({hi, lo} !== {hi_m, lo_m}) begin n_fail++; $display("FAIL rnd%0d_hilo f=%h a=%h b=%h: got %h_%h want %h_%h", i, f, a, b, hi, lo, hi_m, lo_m); end
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_mt_mf();
      test_div();
      test_flush();
      test_reset_mid_div();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Multiply/divide unit for the EX stage, directly downstream of ID's ALU-funct generation. It consumes the 6-bit `funct` code of `OP_SPECIAL` instructions along with both operands, and owns the architectural HI/LO registers. It executes MULT/MULTU in one cycle and DIV/DIVU iteratively, stalling the pipeline until the quotient is ready. It also returns HI/LO for MFHI/MFLO.

## Interface
Parameters:
- `DIV_CYCLES`, 32: number of quotient-bit iterations; fixed at operand width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  EX holds a valid SPECIAL instruction this cycle.
- `funct`  in  6  funct field from ID (`FUNCT_BUS`).
- `operand_1`  in  32  rs value, the dividend / multiplicand / MT source.
- `operand_2`  in  32  rt value, the divisor / multiplier.
- `flush`  in  1  annul the current EX instruction.
- `stall_req`  out  1  hold IF/ID/EX this cycle.
- `result`  out  32  HI for MFHI, LO for MFLO, otherwise 0.
- `hi`, `lo`  out  32 each  architectural HI/LO registers.

## Operation
- Handled functs: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. Any other funct has no effect here.
- FSM states:
  - IDLE: accepts a new operation.
  - RUN: one quotient bit per cycle; the iteration counter runs 0..31.
  - DONE: sign fix-up and HI/LO write.
- MFHI / MFLO: `result` is combinational from `hi` / `lo`. There is no write.
- MTHI / MTLO: in IDLE with `start`, HI (or LO) ← `operand_1` at the clock edge.
- MULT / MULTU: in IDLE with `start`, {HI,LO} ← the 64-bit signed (or unsigned) product at the clock edge. There is no stall.
- DIV / DIVU issue, in IDLE with `start` and `operand_2` ≠ 0:
  - Latch |dividend| and |divisor|. Use absolute values for DIV only.
  - Latch the dividend sign and the quotient sign (sign1 XOR sign2).
  - Go to RUN.
- Divide step: restoring shift-subtract on a 33-bit partial remainder. After 32 RUN cycles, go to DONE.
- DONE:
  - Negate the quotient if the quotient sign is set.
  - The remainder takes the dividend's sign.
  - Write LO ← quotient and HI ← remainder.
  - Return to IDLE unconditionally. A `start` seen in DONE is the same instruction and is ignored.
- Divide by zero: IDLE goes directly to DONE. DONE writes LO ← 0xFFFFFFFF and HI ← `operand_1`. This applies to both DIV and DIVU.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0. This falls out of the absolute-value datapath.
- `flush`:
  - Has priority over every write and over `start`.
  - In any state it forces IDLE at the next edge, with no HI/LO update.
  - `stall_req` is 0 in any cycle where `flush` = 1.

## Timing
- Reset values: `hi` = 0, `lo` = 0, state = IDLE, counter = 0. `stall_req` = 0 and `result` = 0 while `rst_n` is low.
- Reset asserted mid-division aborts immediately. HI/LO are cleared.
- `stall_req` = (IDLE & `start` & DIV/DIVU) | RUN, gated by `!flush`.
- Divide latency: the issue cycle plus 32 RUN cycles are stalled, i.e. 33 stall cycles. DONE is unstalled. HI/LO update at the edge ending DONE, which is the same edge where the instruction leaves EX. Total time in EX is 34 cycles.
- Divide by zero: 1 stall cycle (issue), then DONE. Total time in EX is 2 cycles.
- MUL/MT writes land at the edge ending the issue cycle. The next instruction's MFHI/MFLO sees the new value with no forwarding.

## Structure
- Funct codes go in the shared `funct.v` as `FUNCT_MFHI` … `FUNCT_DIVU`. Widths come from `bus.v` (`FUNCT_BUS`, `DATA_BUS`, a new `DOUBLE_DATA_BUS` of 64 bits).
- The FSM state encoding is local `localparam`s (2 bits).
- One sub-module, `div_iter`, holds the unsigned 32-cycle restoring divider core (start/busy/done, quotient, remainder). Sign handling, HI/LO and the FSM stay in `ex_muldiv`.

## Test plan
- MULT 0xFFFFFFFE × 3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU on the same operands → HI=0x00000002, LO=0xFFFFFFFA. No stall in either case.
- DIVU 100 / 7 → `stall_req` high for exactly 33 cycles. HI=2, LO=0xE at the edge ending DONE. Then DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 5 / 0 → 1 stall cycle, LO=0xFFFFFFFF, HI=5.
- MTHI 0x1234 then MFHI → `result`=0x1234 the next cycle. MTLO 0xABCD then MFLO → 0xABCD. A non-muldiv funct → `result`=0 and no write.
- DIV in progress, `flush` in RUN cycle 10 → `stall_req` 0 that cycle, IDLE next cycle, HI/LO unchanged. A following MULT is accepted normally.
- `rst_n` pulsed low during RUN → immediate IDLE, `hi`=`lo`=0, `stall_req`=0. After reset is released, a new DIVU completes correctly.
